// File: rtl/axi_w_router.sv
// W-channel router: a FIFO of granted AW port IDs selects which slave-side W port is routed downstream.
// Optional macro AXI_W_FIFO_BYPASS_EN enables zero-cycle routing of a push into an empty FIFO.
module axi_w_router #(
    parameter int unsigned AXI_DATA_W  = 64,
    parameter int unsigned AXI_USER_W  = 6,
    parameter int unsigned N_TARG_PORT = 7,
    parameter int unsigned LOG_N_TARG  = $clog2(N_TARG_PORT),
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [N_TARG_PORT-1:0][AXI_DATA_W-1:0]   wdata_i,
    input  logic [N_TARG_PORT-1:0][AXI_DATA_W/8-1:0] wstrb_i,
    input  logic [N_TARG_PORT-1:0]                   wlast_i,
    input  logic [N_TARG_PORT-1:0][AXI_USER_W-1:0]   wuser_i,
    input  logic [N_TARG_PORT-1:0]                   wvalid_i,
    output logic [N_TARG_PORT-1:0]                   wready_o,
    output logic [AXI_DATA_W-1:0]                    wdata_o,
    output logic [AXI_DATA_W/8-1:0]                  wstrb_o,
    output logic                                     wlast_o,
    output logic [AXI_USER_W-1:0]                    wuser_o,
    output logic                                     wvalid_o,
    input  logic                                     wready_i,
    input  logic                                     push_ID_i,
    input  logic [LOG_N_TARG+N_TARG_PORT-1:0]        ID_i,
    output logic                                     grant_FIFO_ID_o
);

    localparam int unsigned ID_W  = LOG_N_TARG + N_TARG_PORT;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [ID_W-1:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic                   head_valid;
    logic                   bypass;
    logic [ID_W-1:0]        head_id;
    logic [N_TARG_PORT-1:0] head_oh;
    logic [LOG_N_TARG-1:0]  head_bin;
    logic                   push, pop, write_en, read_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Grant depends on registered count only, so no path from wready_i.
    assign grant_FIFO_ID_o = (count_q < CNT_W'(FIFO_DEPTH));

    always_comb begin
        head_valid = (count_q != '0);
        head_id    = mem_q[rd_ptr_q];
        bypass     = 1'b0;
`ifdef AXI_W_FIFO_BYPASS_EN
        if ((count_q == '0) && push_ID_i) begin
            head_valid = 1'b1;
            head_id    = ID_i;
            bypass     = 1'b1;
        end
`endif
    end

    assign head_oh  = head_id[N_TARG_PORT-1:0];
    assign head_bin = head_id[ID_W-1:N_TARG_PORT];

    assign wvalid_o = head_valid & (|(wvalid_i & head_oh));
    assign wready_o = {N_TARG_PORT{head_valid & wready_i}} & head_oh;

    always_comb begin
        wdata_o = '0;
        wstrb_o = '0;
        wlast_o = 1'b0;
        wuser_o = '0;
        for (int unsigned i = 0; i < N_TARG_PORT; i++) begin
            if (head_bin == LOG_N_TARG'(i)) begin
                wdata_o = wdata_i[i];
                wstrb_o = wstrb_i[i];
                wlast_o = wlast_i[i];
                wuser_o = wuser_i[i];
            end
        end
    end

    assign pop      = wvalid_o & wready_i & wlast_o;
    assign push     = push_ID_i & grant_FIFO_ID_o;
    // A bypassed ID whose last beat completes in the same cycle never enters storage.
    assign write_en = push & ~(bypass & pop);
    assign read_en  = pop & ~bypass;

    always_comb begin
        rd_ptr_d = read_en  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = write_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q;
        if (write_en && !read_en) begin
            count_d = count_q + 1'b1;
        end else if (!write_en && read_en) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem_q[wr_ptr_q] <= ID_i;
        end
    end

endmodule

// File: doc/axi_w_router.md
AXI_W_ROUTER -- requirements
Module: axi_W_router

Interface
REQ-001 SHALL have parameter AXI_DATA_W, default 64: W data width in bits.
REQ-002 SHALL have parameter AXI_USER_W, default 6: W user width.
REQ-003 SHALL have parameter N_TARG_PORT, default 7: number of slave-side W input ports.
REQ-004 SHALL have parameter LOG_N_TARG, default $clog2(N_TARG_PORT): binary port-index width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4: ID FIFO entries, any value >=2, not required to be a power of two.
REQ-006 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-007 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have ports: wdata_i/wstrb_i/wlast_i/wuser_i  input  [N_TARG_PORT][AXI_DATA_W | AXI_DATA_W/8 | 1 | AXI_USER_W]  per-port W payload.
REQ-009 SHALL have ports: wvalid_i  input  N_TARG_PORT  per-port beat valid; wready_o  output  N_TARG_PORT  per-port beat accept.
REQ-010 SHALL have ports: wdata_o/wstrb_o/wlast_o/wuser_o  output  same widths  routed W payload.
REQ-011 SHALL have ports: wvalid_o  output  1; wready_i  input  1  downstream W handshake.
REQ-012 SHALL have ports: push_ID_i  input  1  push strobe; ID_i  input  LOG_N_TARG+N_TARG_PORT  {BIN_ID, OH_ID} of granted AW port; grant_FIFO_ID_o  output  1  FIFO can accept a push.

Function
REQ-013 SHALL store ID_i in the FIFO tail on each rising edge where push_ID_i=1 and grant_FIFO_ID_o=1; push_ID_i with grant_FIFO_ID_o=0 is ignored.
REQ-014 SHALL drive grant_FIFO_ID_o = (count < FIFO_DEPTH); full FIFO deasserts grant even if a pop occurs in the same cycle (no full-pass-through).
REQ-015 SHALL select the active port from the FIFO head: OH_ID for handshake gating, BIN_ID for payload mux.
REQ-016 SHALL drive wvalid_o = head_valid & |(wvalid_i & OH_ID); wready_o[i] = head_valid & OH_ID[i] & wready_i; all non-selected wready_o bits 0.
REQ-017 SHALL drive wdata_o/wstrb_o/wlast_o/wuser_o = port[BIN_ID] payload; value is don't-care when wvalid_o=0.
REQ-018 SHALL pop the head when wvalid_o & wready_i & wlast_o; non-last beats do not pop.
REQ-019 SHALL apply push and pop in the same cycle with count unchanged and both pointers advancing.
REQ-020 SHALL wrap read and write pointers from FIFO_DEPTH-1 to 0; count width $clog2(FIFO_DEPTH+1).
REQ-021 SHALL add no combinational path from wready_i to grant_FIFO_ID_o.
REQ-022 SHALL route bursts strictly in push order; beats from a non-head port stall (wready_o=0) regardless of wvalid_i.

Reset
REQ-023 SHALL on rst_n=0 asynchronously clear read pointer, write pointer and count to 0.
REQ-024 SHALL during and after reset drive wvalid_o=0, wready_o=0, grant_FIFO_ID_o=1.
REQ-025 SHALL discard all queued IDs on reset asserted mid-burst; no beat is routed until a new push.

Configuration
REQ-026 SHALL support macro AXI_W_FIFO_BYPASS_EN.
REQ-027 With AXI_W_FIFO_BYPASS_EN defined, when count=0 and push_ID_i=1, head SHALL be ID_i combinationally (zero-cycle routing); if a last beat is accepted that same cycle the ID SHALL NOT be written.
REQ-028 Without AXI_W_FIFO_BYPASS_EN, head_valid SHALL be (count!=0) only; minimum push-to-wvalid_o latency is one cycle.

Verification
REQ-029 Reset: hold rst_n=0, drive all wvalid_i=1 -> wvalid_o=0, wready_o=0, grant_FIFO_ID_o=1.
REQ-030 Ordering: push port 3 then port 1, both ports present 4-beat bursts concurrently -> output carries all 4 beats of port 3, then port 1; wready_o[1]=0 until port 3 wlast accepted.
REQ-031 Full: FIFO_DEPTH=4, 4 pushes with no W traffic -> grant_FIFO_ID_o=0 after 4th push; 5th push ignored; after one last-beat pop grant returns to 1 next cycle.
REQ-032 Backpressure: port 0 single-beat, wready_i=0 for 3 cycles -> wvalid_o held 1, payload stable, no pop until wready_i=1.
REQ-033 Wrap: FIFO_DEPTH=3, 10 push/pop pairs cycling ports 0..6 -> each burst routed to correct port, count never exceeds 3.
REQ-034 Bypass: with AXI_W_FIFO_BYPASS_EN, empty FIFO, push port 2 while port 2 presents wlast=1, wready_i=1 -> beat accepted same cycle, count stays 0; without macro -> beat accepted next cycle, count 1 then 0.
